// File: rtl/mseq_load_ng.sv
// Matrix sequential load unit: packs nibbles from AXI R beats into
// multi-exit lane entries held in a circular buffer and streams them out.
module mseq_load_ng #(
  parameter int unsigned DLEN         = 64,
  parameter int unsigned NrExits      = 2,
  parameter int unsigned AxiDataWidth = 64,
  parameter int unsigned BufDepth     = 4,
  parameter int unsigned RmnWidth     = 8,
  localparam int unsigned EntryNbs    = (DLEN / 4) * NrExits,
  localparam int unsigned BusNbs      = AxiDataWidth / 4,
  localparam int unsigned BusNSize    = $clog2(BusNbs),
  localparam int unsigned OccW        = $clog2(BufDepth) + 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    axi_r_valid_i,
  output logic                    axi_r_ready_o,
  input  logic [AxiDataWidth-1:0] axi_r_data_i,
  input  logic [1:0]              axi_r_resp_i,
  input  logic                    txn_valid_i,
  output logic                    txn_ready_o,
  input  logic [BusNSize-1:0]     txn_addr_lo_i,
  input  logic [BusNSize:0]       txn_lbn_i,
  input  logic [RmnWidth-1:0]     txn_rmn_beat_i,
  input  logic                    txn_is_head_i,
  input  logic                    txn_is_final_i,
  input  logic                    flush_i,
  output logic                    tx_valid_o,
  input  logic                    tx_ready_i,
  output logic [EntryNbs*4-1:0]   tx_data_o,
  output logic [EntryNbs-1:0]     tx_en_o,
  output logic                    tx_last_o,
  output logic [OccW-1:0]         occupancy_o,
  output logic                    err_o
);

  localparam int unsigned WinW = BusNSize + 2;
  localparam int unsigned PtrW = $clog2(EntryNbs) + 1;
  localparam int unsigned NW   = (PtrW > WinW) ? PtrW : WinW;
  localparam int unsigned AW   = $clog2(BufDepth);
  localparam int unsigned EW   = EntryNbs * 4;
  localparam int unsigned SW   = EW + AxiDataWidth;

  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_e;

  state_e              state_q;
  logic [EW-1:0]       buf_data_q [BufDepth];
  logic [EntryNbs-1:0] buf_en_q   [BufDepth];
  logic [BufDepth-1:0] buf_last_q;
  logic [AW:0]         enq_ptr_q, deq_ptr_q;
  logic [NW-1:0]       bus_nb_cnt_q, seq_nb_ptr_q;
  logic                err_q;
  logic                tx_hold_q;

  logic [AW-1:0]       enq_idx, deq_idx;
  logic                empty, full;
  logic [NW-1:0]       win_lo, win_hi, avail, space, n_nbs, seq_next, rd_off;
  logic                final_beat, deq_fire, commit, split, consume, enq_fire, drain_ack;
  logic [SW-1:0]       bus_shift;
  logic [EW-1:0]       ent_shift;
  logic [EntryNbs:0]   cnt_mask;
  logic [EntryNbs-1:0] wr_en;
  logic [EW-1:0]       wr_data;

  assign enq_idx = enq_ptr_q[AW-1:0];
  assign deq_idx = deq_ptr_q[AW-1:0];
  assign empty   = (enq_ptr_q == deq_ptr_q);
  assign full    = (enq_idx == deq_idx) && (enq_ptr_q[AW] != deq_ptr_q[AW]);

  // Nibble window of the presented beat and room left in the entry being built.
  always_comb begin
    win_lo = txn_is_head_i ? NW'(txn_addr_lo_i) : '0;
    win_hi = (txn_rmn_beat_i == '0) ? NW'(txn_lbn_i) : NW'(BusNbs);
    avail  = win_hi - win_lo - bus_nb_cnt_q;
    space  = NW'(EntryNbs) - seq_nb_ptr_q;
    rd_off = win_lo + bus_nb_cnt_q;
  end

  assign final_beat = txn_is_final_i && (txn_rmn_beat_i == '0);
  assign deq_fire   = !empty && tx_ready_i && !flush_i;
  assign commit     = (state_q == ACTIVE) && axi_r_valid_i && txn_valid_i && !flush_i
                      && (!full || deq_fire);
  assign split      = (avail > space);
  assign n_nbs      = split ? space : avail;
  assign consume    = commit && !split;
  assign seq_next   = seq_nb_ptr_q + n_nbs;
  assign enq_fire   = commit && (split || (seq_next == NW'(EntryNbs)) || final_beat);
  assign drain_ack  = (state_q == DRAIN) && !flush_i;

  assign axi_r_ready_o = consume || drain_ack;
  assign txn_ready_o   = axi_r_ready_o;

  // Align the selected bus nibbles to the entry write position and build the enable mask.
  always_comb begin
    wr_data   = '0;
    bus_shift = {{EW{1'b0}}, axi_r_data_i} >> {rd_off, 2'b00};
    ent_shift = EW'(bus_shift << {seq_nb_ptr_q, 2'b00});
    cnt_mask  = ({{EntryNbs{1'b0}}, 1'b1} << n_nbs) - {{EntryNbs{1'b0}}, 1'b1};
    wr_en     = EntryNbs'(cnt_mask << seq_nb_ptr_q);
    for (int unsigned j = 0; j < EntryNbs; j++) begin
      wr_data[4*j +: 4] = wr_en[j] ? ent_shift[4*j +: 4] : 4'h0;
    end
  end

  // Entry storage: wipe on reset/flush, retire the dequeued slot, merge commit writes.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      for (int unsigned i = 0; i < BufDepth; i++) begin
        buf_data_q[i] <= '0;
        buf_en_q[i]   <= '0;
      end
      buf_last_q <= '0;
    end else begin
      if (deq_fire) begin
        buf_data_q[deq_idx] <= '0;
        buf_en_q[deq_idx]   <= '0;
        buf_last_q[deq_idx] <= 1'b0;
      end
      // When full, the enq slot is the one leaving this cycle, so the write starts from a clean slot.
      if (commit) begin
        buf_data_q[enq_idx] <= (full ? '0 : buf_data_q[enq_idx]) | wr_data;
        buf_en_q[enq_idx]   <= (full ? '0 : buf_en_q[enq_idx]) | wr_en;
        buf_last_q[enq_idx] <= consume && final_beat;
      end
    end
  end

  // Control FSM, buffer pointers, split counters and sticky error flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      enq_ptr_q    <= '0;
      deq_ptr_q    <= '0;
      bus_nb_cnt_q <= '0;
      seq_nb_ptr_q <= '0;
      err_q        <= 1'b0;
    end else if (flush_i) begin
      enq_ptr_q    <= '0;
      deq_ptr_q    <= '0;
      bus_nb_cnt_q <= '0;
      seq_nb_ptr_q <= '0;
      err_q        <= 1'b0;
      if ((state_q == ACTIVE) && (bus_nb_cnt_q != '0)) begin
        state_q <= DRAIN;
      end
    end else begin
      if (enq_fire) begin
        enq_ptr_q <= enq_ptr_q + (AW+1)'(1);
      end
      if (deq_fire) begin
        deq_ptr_q <= deq_ptr_q + (AW+1)'(1);
      end
      if (consume && (axi_r_resp_i != 2'b00)) begin
        err_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (txn_valid_i) begin
            state_q      <= ACTIVE;
            bus_nb_cnt_q <= '0;
            seq_nb_ptr_q <= '0;
          end
        end
        ACTIVE: begin
          if (commit) begin
            if (split) begin
              seq_nb_ptr_q <= '0;
              bus_nb_cnt_q <= bus_nb_cnt_q + n_nbs;
            end else begin
              bus_nb_cnt_q <= '0;
              if (final_beat || (seq_next == NW'(EntryNbs))) begin
                seq_nb_ptr_q <= '0;
              end else begin
                seq_nb_ptr_q <= seq_next;
              end
              if (final_beat) begin
                state_q <= IDLE;
              end
            end
          end
        end
        DRAIN: begin
          state_q      <= IDLE;
          bus_nb_cnt_q <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Sanity checks on presented beats and on downstream valid stability.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_hold_q <= 1'b0;
    end else begin
      tx_hold_q <= tx_valid_o && !tx_ready_i && !flush_i;
      if ((state_q == ACTIVE) && axi_r_valid_i && txn_valid_i) begin
        assert (win_hi <= NW'(BusNbs));
        assert (avail <= NW'(BusNbs));
        if (txn_rmn_beat_i == '0) begin
          assert (txn_lbn_i != '0);
        end
      end
      if (tx_hold_q) begin
        assert (tx_valid_o);
      end
    end
  end

  assign tx_valid_o  = !empty;
  assign tx_data_o   = buf_data_q[deq_idx];
  assign tx_en_o     = buf_en_q[deq_idx];
  assign tx_last_o   = buf_last_q[deq_idx];
  assign occupancy_o = enq_ptr_q - deq_ptr_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_mseq_load_ng.sv
// Bench for mseq_load_ng: directed scenarios with random data, reference
// model builds expected entries from the per-request nibble stream.
module tb_mseq_load_ng;

  localparam int unsigned EntryNbs = 32;
  localparam int unsigned BusNbs   = 16;

  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  resp;
    logic [3:0]  lo;
    logic [4:0]  lbn;
    logic [7:0]  rmn;
    logic        head;
    logic        fin;
  } beat_t;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic          rst_i;
  logic          axi_r_valid_i, axi_r_ready_o;
  logic [63:0]   axi_r_data_i;
  logic [1:0]    axi_r_resp_i;
  logic          txn_valid_i, txn_ready_o;
  logic [3:0]    txn_addr_lo_i;
  logic [4:0]    txn_lbn_i;
  logic [7:0]    txn_rmn_beat_i;
  logic          txn_is_head_i, txn_is_final_i;
  logic          flush_i;
  logic          tx_valid_o, tx_ready_i;
  logic [127:0]  tx_data_o;
  logic [31:0]   tx_en_o;
  logic          tx_last_o;
  logic [2:0]    occupancy_o;
  logic          err_o;

  mseq_load_ng #(
    .DLEN(64), .NrExits(2), .AxiDataWidth(64), .BufDepth(4), .RmnWidth(8)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .axi_r_valid_i(axi_r_valid_i), .axi_r_ready_o(axi_r_ready_o),
    .axi_r_data_i(axi_r_data_i), .axi_r_resp_i(axi_r_resp_i),
    .txn_valid_i(txn_valid_i), .txn_ready_o(txn_ready_o),
    .txn_addr_lo_i(txn_addr_lo_i), .txn_lbn_i(txn_lbn_i),
    .txn_rmn_beat_i(txn_rmn_beat_i), .txn_is_head_i(txn_is_head_i),
    .txn_is_final_i(txn_is_final_i), .flush_i(flush_i),
    .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
    .tx_data_o(tx_data_o), .tx_en_o(tx_en_o), .tx_last_o(tx_last_o),
    .occupancy_o(occupancy_o), .err_o(err_o)
  );

  int n_checks = 0;
  int n_pass   = 0;

  beat_t        bq[$];
  logic [3:0]   cur_nibs[$];
  logic [127:0] exp_d[$], obs_d[$];
  logic [31:0]  exp_en[$], obs_en[$];
  logic         exp_last[$], obs_last[$];
  logic         last_took, last_deq, any_bad;
  int           holds, pulses, rdy_mode;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Append one txn's beats to the stimulus queue and its nibbles to the request stream.
  task automatic add_txn(input int lo, input int nb, input int lbn, input bit fin, input int bad);
    beat_t b;
    int k0, k1;
    for (int i = 0; i < nb; i++) begin
      b.data = {$urandom, $urandom};
      b.resp = (i == bad) ? 2'b10 : 2'b00;
      b.lo   = 4'(lo);
      b.lbn  = 5'(lbn);
      b.rmn  = 8'(nb - 1 - i);
      b.head = (i == 0);
      b.fin  = fin;
      bq.push_back(b);
      if (i == bad) any_bad = 1'b1;
      k0 = (i == 0) ? lo : 0;
      k1 = (i == nb - 1) ? lbn : BusNbs;
      for (int k = k0; k < k1; k++) cur_nibs.push_back(b.data[4*k +: 4]);
    end
  endtask

  // Close a request: chop its nibble stream into entries, last one tagged.
  task automatic end_req(input bit keep);
    logic [127:0] d;
    logic [31:0]  en;
    while (cur_nibs.size() > 0) begin
      d = '0;
      en = '0;
      for (int k = 0; k < EntryNbs && cur_nibs.size() > 0; k++) begin
        d[4*k +: 4] = cur_nibs.pop_front();
        en[k] = 1'b1;
      end
      if (keep) begin
        exp_d.push_back(d);
        exp_en.push_back(en);
        exp_last.push_back(cur_nibs.size() == 0);
      end
    end
  endtask

  task automatic drive_front();
    if (bq.size() > 0) begin
      axi_r_valid_i  = 1'b1;
      txn_valid_i    = 1'b1;
      axi_r_data_i   = bq[0].data;
      axi_r_resp_i   = bq[0].resp;
      txn_addr_lo_i  = bq[0].lo;
      txn_lbn_i      = bq[0].lbn;
      txn_rmn_beat_i = bq[0].rmn;
      txn_is_head_i  = bq[0].head;
      txn_is_final_i = bq[0].fin;
    end else begin
      axi_r_valid_i = 1'b0;
      txn_valid_i   = 1'b0;
    end
  endtask

  task automatic cycle();
    @(negedge clk_i);
    last_deq  = tx_valid_o && tx_ready_i && !flush_i;
    last_took = axi_r_ready_o;
    if (last_deq) begin
      obs_d.push_back(tx_data_o);
      obs_en.push_back(tx_en_o);
      obs_last.push_back(tx_last_o);
    end
    if (axi_r_valid_i && !axi_r_ready_o) holds++;
    if (axi_r_ready_o) pulses++;
    @(posedge clk_i);
    #1;
    case (rdy_mode)
      0:       tx_ready_i = 1'b0;
      1:       tx_ready_i = 1'b1;
      default: tx_ready_i = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic run_beats(input string tag, input int max_cycles);
    int c;
    c = 0;
    while (bq.size() > 0 && c < max_cycles) begin
      drive_front();
      cycle();
      if (last_took) void'(bq.pop_front());
      c++;
    end
    chk({tag, "_beats_left"}, 128'(bq.size()), 128'(0));
    bq.delete();
    drive_front();
  endtask

  task automatic drain(input string tag);
    int c;
    c = 0;
    rdy_mode = 1;
    tx_ready_i = 1'b1;
    while (tx_valid_o && c < 200) begin
      cycle();
      c++;
    end
    chk({tag, "_drained"}, 128'(tx_valid_o), 128'(0));
  endtask

  task automatic compare_all(input string tag);
    chk({tag, "_count"}, 128'(obs_d.size()), 128'(exp_d.size()));
    while (obs_d.size() > 0 && exp_d.size() > 0) begin
      chk({tag, "_data"}, obs_d.pop_front(), exp_d.pop_front());
      chk({tag, "_en"}, 128'(obs_en.pop_front()), 128'(exp_en.pop_front()));
      chk({tag, "_last"}, 128'(obs_last.pop_front()), 128'(exp_last.pop_front()));
    end
    obs_d.delete(); obs_en.delete(); obs_last.delete();
    exp_d.delete(); exp_en.delete(); exp_last.delete();
  endtask

  initial begin
    int c, nt, nb, lo, lbn;
    rst_i = 1'b1; flush_i = 1'b0; tx_ready_i = 1'b0; rdy_mode = 0; any_bad = 1'b0;
    holds = 0; pulses = 0; last_took = 1'b0; last_deq = 1'b0;
    drive_front();
    axi_r_data_i = '0; axi_r_resp_i = '0; txn_addr_lo_i = '0; txn_lbn_i = 5'd16;
    txn_rmn_beat_i = '0; txn_is_head_i = 1'b0; txn_is_final_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;

    // Reset state
    chk("rst_tx_valid", 128'(tx_valid_o), 128'(0));
    chk("rst_occ", 128'(occupancy_o), 128'(0));
    chk("rst_err", 128'(err_o), 128'(0));
    chk("rst_data", tx_data_o, 128'(0));
    chk("rst_en", 128'(tx_en_o), 128'(0));
    chk("rst_last", 128'(tx_last_o), 128'(0));
    chk("rst_rready", 128'(axi_r_ready_o), 128'(0));

    // Aligned 4-beat request: two full entries, second tagged last
    rdy_mode = 0; tx_ready_i = 1'b0;
    add_txn(0, 4, 16, 1'b1, -1); end_req(1'b1);
    run_beats("aligned", 40);
    chk("aligned_occ", 128'(occupancy_o), 128'(2));
    drain("aligned");
    compare_all("aligned");

    // Offset head, single final beat: nibbles 6..9
    add_txn(6, 1, 10, 1'b1, -1); end_req(1'b1);
    run_beats("offset", 40);
    drain("offset");
    if (obs_en.size() > 0) chk("offset_en", 128'(obs_en[0]), 128'(32'h0000_000F));
    compare_all("offset");

    // Entry boundary inside a beat: one split, beat held once
    holds = 0; pulses = 0;
    add_txn(4, 3, 16, 1'b1, -1); end_req(1'b1);
    run_beats("split", 40);
    chk("split_holds", 128'(holds), 128'(2));
    chk("split_pulses", 128'(pulses), 128'(3));
    drain("split");
    compare_all("split");

    // Full buffer back-pressure, then enq and deq in the same cycle
    rdy_mode = 0; tx_ready_i = 1'b0;
    for (int r = 0; r < 6; r++) begin
      add_txn(0, 1, 16, 1'b1, -1); end_req(1'b1);
    end
    c = 0;
    while (occupancy_o != 3'd4 && c < 60) begin
      drive_front(); cycle(); if (last_took) void'(bq.pop_front()); c++;
    end
    repeat (2) begin
      drive_front(); cycle(); if (last_took) void'(bq.pop_front());
    end
    chk("full_occ", 128'(occupancy_o), 128'(4));
    chk("full_rready", 128'(axi_r_ready_o), 128'(0));
    rdy_mode = 1; tx_ready_i = 1'b1;
    drive_front(); cycle();
    chk("full_took", 128'(last_took), 128'(1));
    chk("full_deq", 128'(last_deq), 128'(1));
    chk("full_occ_same", 128'(occupancy_o), 128'(4));
    if (last_took) void'(bq.pop_front());
    run_beats("full", 60);
    drain("full");
    compare_all("full");

    // Sticky error, then flush clears buffer and error
    rdy_mode = 0; tx_ready_i = 1'b0;
    chk("err_before", 128'(err_o), 128'(0));
    add_txn(0, 2, 16, 1'b1, 0); end_req(1'b0);
    run_beats("err", 40);
    chk("err_sticky", 128'(err_o), 128'(1));
    chk("err_occ", 128'(occupancy_o), 128'(1));
    flush_i = 1'b1; cycle(); flush_i = 1'b0;
    chk("flush_err", 128'(err_o), 128'(0));
    chk("flush_valid", 128'(tx_valid_o), 128'(0));
    chk("flush_occ", 128'(occupancy_o), 128'(0));
    any_bad = 1'b0;

    // Flush while a beat is half-committed: drain discards it
    rdy_mode = 0; tx_ready_i = 1'b0;
    add_txn(4, 4, 16, 1'b1, -1); end_req(1'b0);
    c = 0;
    while (occupancy_o != 3'd1 && c < 40) begin
      drive_front(); cycle(); if (last_took) void'(bq.pop_front()); c++;
    end
    chk("midflush_split_occ", 128'(occupancy_o), 128'(1));
    flush_i = 1'b1; drive_front(); cycle(); flush_i = 1'b0;
    chk("midflush_no_hs", 128'(last_took), 128'(0));
    drive_front(); cycle();
    chk("midflush_drain_hs", 128'(last_took), 128'(1));
    bq.delete(); drive_front(); cycle();
    chk("midflush_occ", 128'(occupancy_o), 128'(0));
    chk("midflush_valid", 128'(tx_valid_o), 128'(0));
    chk("midflush_no_entry", 128'(obs_d.size()), 128'(0));
    add_txn(2, 1, 9, 1'b1, -1); end_req(1'b1);
    run_beats("after_flush", 40);
    drain("after_flush");
    compare_all("after_flush");

    // Random requests with random downstream readiness
    rdy_mode = 2;
    for (int r = 0; r < 8; r++) begin
      nt = $urandom_range(1, 3);
      for (int t = 0; t < nt; t++) begin
        nb = $urandom_range(1, 4);
        lo = $urandom_range(0, 15);
        lbn = (nb == 1) ? $urandom_range(lo + 1, 16) : $urandom_range(1, 16);
        add_txn(lo, nb, lbn, (t == nt - 1), ($urandom_range(0, 9) == 0) ? 0 : -1);
      end
      end_req(1'b1);
    end
    run_beats("rand", 3000);
    drain("rand");
    compare_all("rand");
    chk("rand_err", 128'(err_o), 128'(any_bad));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
